// File: rtl/renkon_ctrl_store_if.sv
// Pipeline control bundle passed between ctrl stages: start/valid/stop strobes.
interface ctrl_bus;
    logic start;
    logic valid;
    logic stop;

    modport master (output start, output valid, output stop);
    modport slave  (input  start, input  valid, input  stop);
endinterface

// File: rtl/renkon_ctrl_store.sv
// Store stage: writes the valid-qualified result stream into the output memory
// at base+count, with overrun/underrun tracking and a one-cycle done pulse.
module renkon_ctrl_store #(
    parameter int DWIDTH = 16,
    parameter int OADDR  = 12
) (
    input  logic              clk,
    input  logic              xrst,
    ctrl_bus.slave            in_ctrl,
    input  logic [DWIDTH-1:0] in_data,
    input  logic [OADDR-1:0]  out_base,
    input  logic [OADDR-1:0]  out_len,
    output logic              mem_we,
    output logic [OADDR-1:0]  mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [OADDR-1:0]  count,
    output logic              err_over,
    output logic              err_under
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [OADDR-1:0]   base_q;
    logic [OADDR-1:0]   len_q;

    logic               room;
    logic               wr_now;
    logic [OADDR-1:0]   wr_addr;
    logic [OADDR-1:0]   count_after;

    // count never exceeds len, so count+1 cannot wrap when a write is accepted
    always_comb begin
        room        = (count < len_q);
        wr_now      = in_ctrl.valid && room;
        wr_addr     = base_q + count;
        count_after = wr_now ? (count + 1'b1) : count;
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state     <= IDLE;
            base_q    <= '0;
            len_q     <= '0;
            count     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_over  <= 1'b0;
            err_under <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            // start wins in every state; a same-cycle valid lands on the new base
            if (in_ctrl.start) begin
                state     <= RECV;
                busy      <= 1'b1;
                base_q    <= out_base;
                len_q     <= out_len;
                err_under <= 1'b0;
                if (in_ctrl.valid && (out_len != '0)) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= out_base;
                    mem_wdata <= in_data;
                    count     <= {{(OADDR-1){1'b0}}, 1'b1};
                    err_over  <= 1'b0;
                end else begin
                    count    <= '0;
                    err_over <= in_ctrl.valid;
                end
            end else begin
                case (state)
                    RECV: begin
                        if (in_ctrl.valid) begin
                            if (room) begin
                                mem_we    <= 1'b1;
                                mem_addr  <= wr_addr;
                                mem_wdata <= in_data;
                            end else begin
                                err_over <= 1'b1;
                            end
                        end
                        count <= count_after;
                        if (in_ctrl.stop) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            err_under <= (count_after < len_q);
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_renkon_ctrl_store.sv
// Bench for renkon_ctrl_store: directed scenarios plus random traffic, checked
// every cycle against a transfer-level reference model.
module tb_renkon_ctrl_store;

    logic        clk;
    logic        xrst;
    logic [15:0] in_data;
    logic [11:0] out_base;
    logic [11:0] out_len;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        busy;
    logic        done;
    logic [11:0] count;
    logic        err_over;
    logic        err_under;

    ctrl_bus cb ();

    renkon_ctrl_store #(.DWIDTH(16), .OADDR(12)) dut (
        .clk       (clk),
        .xrst      (xrst),
        .in_ctrl   (cb),
        .in_data   (in_data),
        .out_base  (out_base),
        .out_len   (out_len),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .count     (count),
        .err_over  (err_over),
        .err_under (err_under)
    );

    int total = 0;
    int bad   = 0;

    // reference model: a transfer is active or not; outputs follow from that
    bit          m_act;
    logic [11:0] m_base, m_len, m_cnt, m_addr;
    logic [15:0] m_wd;
    bit          m_we, m_done, m_eo, m_eu;

    logic [11:0] wq_addr[$];
    logic [15:0] wq_data[$];
    int          done_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check_output(input string name, input logic [31:0] act,
                                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic model_clear();
        m_act = 0; m_base = '0; m_len = '0; m_cnt = '0; m_addr = '0;
        m_wd = '0; m_we = 0; m_done = 0; m_eo = 0; m_eu = 0;
    endtask

    task automatic model_write();
        if (m_cnt < m_len) begin
            m_we   = 1;
            m_addr = m_base + m_cnt;
            m_wd   = in_data;
            m_cnt  = m_cnt + 12'd1;
        end else begin
            m_eo = 1;
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge xrst);
            if (!xrst) begin
                model_clear();
            end else begin
                m_we   = 0;
                m_done = 0;
                if (cb.start) begin
                    m_act = 1; m_base = out_base; m_len = out_len; m_cnt = '0;
                    m_eo = 0; m_eu = 0;
                    if (cb.valid) model_write();
                end else if (m_act) begin
                    if (cb.valid) model_write();
                    if (cb.stop) begin
                        m_eu   = (m_cnt < m_len);
                        m_act  = 0;
                        m_done = 1;
                    end
                end
            end
        end
    end

    // per-cycle compare plus a log of observed writes for the directed checks
    initial begin
        forever begin
            @(negedge clk);
            if (xrst) begin
                check_output("mem_we", 32'(mem_we), 32'(m_we));
                check_output("mem_addr", 32'(mem_addr), 32'(m_addr));
                check_output("mem_wdata", 32'(mem_wdata), 32'(m_wd));
                check_output("busy", 32'(busy), 32'(m_act));
                check_output("done", 32'(done), 32'(m_done));
                check_output("count", 32'(count), 32'(m_cnt));
                check_output("err_over", 32'(err_over), 32'(m_eo));
                check_output("err_under", 32'(err_under), 32'(m_eu));
                if (mem_we) begin
                    wq_addr.push_back(mem_addr);
                    wq_data.push_back(mem_wdata);
                end
                if (done) done_cnt++;
            end
        end
    end

    task automatic apply_stimulus(input bit s, input bit v, input bit p, input logic [15:0] d);
        cb.start = s;
        cb.valid = v;
        cb.stop  = p;
        in_data  = d;
        @(posedge clk);
        #2;
    endtask

    task automatic new_test(input logic [11:0] b, input logic [11:0] l);
        wq_addr.delete();
        wq_data.delete();
        done_cnt = 0;
        out_base = b;
        out_len  = l;
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_we"}, 32'(mem_we), 32'd0);
        check_output({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check_output({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        check_output({tag, "_busy"}, 32'(busy), 32'd0);
        check_output({tag, "_done"}, 32'(done), 32'd0);
        check_output({tag, "_count"}, 32'(count), 32'd0);
        check_output({tag, "_eo"}, 32'(err_over), 32'd0);
        check_output({tag, "_eu"}, 32'(err_under), 32'd0);
    endtask

    initial begin
        xrst = 1'b0;
        cb.start = 0; cb.valid = 0; cb.stop = 0;
        in_data = '0; out_base = '0; out_len = '0;
        done_cnt = 0;
        #3;
        check_all_zero("reset");
        #9 xrst = 1'b1;
        @(posedge clk); #2;

        // nominal
        new_test(12'h100, 12'd4);
        apply_stimulus(1, 0, 0, 16'h0);
        for (int i = 1; i <= 4; i++) apply_stimulus(0, 1, 0, 16'(i));
        apply_stimulus(0, 0, 1, 16'h0);
        apply_stimulus(0, 0, 0, 16'h0);
        apply_stimulus(0, 0, 0, 16'h0);
        check_output("nom_nwrites", 32'(wq_addr.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_output("nom_addr", 32'(wq_addr[i]), 32'h100 + 32'(i));
            check_output("nom_data", 32'(wq_data[i]), 32'(i + 1));
        end
        check_output("nom_done_cnt", 32'(done_cnt), 32'd1);
        check_output("nom_count", 32'(count), 32'd4);
        check_output("nom_model_count", 32'(m_cnt), 32'd4);
        check_output("nom_errs", 32'({err_over, err_under}), 32'd0);

        // overrun
        new_test(12'h040, 12'd2);
        apply_stimulus(1, 0, 0, 16'h0);
        for (int i = 0; i < 3; i++) apply_stimulus(0, 1, 0, 16'hA0 + 16'(i));
        apply_stimulus(0, 0, 1, 16'h0);
        apply_stimulus(0, 0, 0, 16'h0);
        check_output("ovr_nwrites", 32'(wq_addr.size()), 32'd2);
        check_output("ovr_err_over", 32'(err_over), 32'd1);
        check_output("ovr_err_under", 32'(err_under), 32'd0);
        check_output("ovr_count", 32'(count), 32'd2);

        // underrun with valid+stop together
        new_test(12'h300, 12'd3);
        apply_stimulus(1, 0, 0, 16'h0);
        apply_stimulus(0, 1, 0, 16'h11);
        apply_stimulus(0, 1, 1, 16'h22);
        check_output("und_done", 32'(done), 32'd1);
        check_output("und_err_under", 32'(err_under), 32'd1);
        check_output("und_count", 32'(count), 32'd2);
        apply_stimulus(0, 0, 0, 16'h0);
        check_output("und_done_gone", 32'(done), 32'd0);
        check_output("und_nwrites", 32'(wq_addr.size()), 32'd2);
        check_output("und_data1", 32'(wq_data[1]), 32'h22);

        // address wrap
        new_test(12'hFFE, 12'd4);
        apply_stimulus(1, 0, 0, 16'h0);
        for (int i = 0; i < 4; i++) apply_stimulus(0, 1, 0, 16'h50 + 16'(i));
        apply_stimulus(0, 0, 1, 16'h0);
        apply_stimulus(0, 0, 0, 16'h0);
        check_output("wrap_a0", 32'(wq_addr[0]), 32'hFFE);
        check_output("wrap_a1", 32'(wq_addr[1]), 32'hFFF);
        check_output("wrap_a2", 32'(wq_addr[2]), 32'h000);
        check_output("wrap_a3", 32'(wq_addr[3]), 32'h001);
        check_output("wrap_eu", 32'(err_under), 32'd0);

        // restart mid-transfer clears the overrun and rebases
        new_test(12'h100, 12'd1);
        apply_stimulus(1, 0, 0, 16'h0);
        apply_stimulus(0, 1, 0, 16'h1);
        apply_stimulus(0, 1, 0, 16'h2);
        check_output("rst_pre_eo", 32'(err_over), 32'd1);
        out_base = 12'h200;
        out_len  = 12'd4;
        apply_stimulus(1, 1, 0, 16'h55);
        check_output("rs_we", 32'(mem_we), 32'd1);
        check_output("rs_addr", 32'(mem_addr), 32'h200);
        check_output("rs_count", 32'(count), 32'd1);
        check_output("rs_errs", 32'({err_over, err_under}), 32'd0);
        apply_stimulus(0, 0, 1, 16'h0);
        apply_stimulus(0, 0, 0, 16'h0);

        // zero-length transfer
        new_test(12'h010, 12'd0);
        apply_stimulus(1, 0, 0, 16'h0);
        apply_stimulus(0, 1, 0, 16'h7);
        apply_stimulus(0, 0, 1, 16'h0);
        check_output("zl_done", 32'(done), 32'd1);
        check_output("zl_eo", 32'(err_over), 32'd1);
        check_output("zl_eu", 32'(err_under), 32'd0);
        apply_stimulus(0, 0, 0, 16'h0);
        check_output("zl_nwrites", 32'(wq_addr.size()), 32'd0);

        // asynchronous reset mid-transfer
        new_test(12'h400, 12'd4);
        apply_stimulus(1, 0, 0, 16'h0);
        apply_stimulus(0, 1, 0, 16'h1);
        apply_stimulus(0, 1, 0, 16'h2);
        xrst = 1'b0;
        #1;
        check_all_zero("amid");
        wq_addr.delete();
        wq_data.delete();
        done_cnt = 0;
        apply_stimulus(0, 1, 0, 16'h3);
        xrst = 1'b1;
        for (int i = 0; i < 3; i++) apply_stimulus(0, 1, 0, 16'h4);
        apply_stimulus(0, 1, 1, 16'h5);
        apply_stimulus(0, 0, 0, 16'h0);
        check_output("post_rst_writes", 32'(wq_addr.size()), 32'd0);
        check_output("post_rst_done", 32'(done_cnt), 32'd0);
        check_output("post_rst_count", 32'(count), 32'd0);

        // random traffic, with the occasional reset
        for (int n = 0; n < 3000; n++) begin
            bit s, v, p;
            if ($urandom_range(0, 499) == 0) begin
                xrst = 1'b0;
                apply_stimulus(0, 0, 0, 16'h0);
                xrst = 1'b1;
            end
            s = m_act ? ($urandom_range(0, 31) == 0) : ($urandom_range(0, 3) == 0);
            v = ($urandom_range(0, 1) == 1);
            p = ($urandom_range(0, 7) == 0);
            out_base = 12'($urandom);
            out_len  = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, 6));
            apply_stimulus(s, v, p, 16'($urandom));
        end
        apply_stimulus(0, 0, 0, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
